// File: rtl/eq_band_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eq_band_mixer: collects one sample per EQ band, applies per-band Q2.14     |
// | gains with one shared multiplier, rounds/saturates to a DATA_W sample.     |
// | Optional: EQ_MIX_CLIP_CNT_EN adds a saturating clip_cnt output.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module eq_band_mixer #(
    parameter int N_BAND = 5,
    parameter int DATA_W = 16,
    parameter int GAIN_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BAND-1:0]        band_vld,
    input  logic [N_BAND*DATA_W-1:0] band_data,
    input  logic                     gain_we,
    input  logic [2:0]               gain_addr,
    input  logic [GAIN_W-1:0]        gain_wdata,
    input  logic                     ovr_clr,
    output logic [DATA_W-1:0]        y_out,
    output logic                     y_valid,
    output logic                     busy,
    output logic                     overrun
`ifdef EQ_MIX_CLIP_CNT_EN
    ,
    output logic [15:0]              clip_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_MAC     = 2'd1,
        ST_OUT     = 2'd2
    } state_t;

    localparam int c_prod_w = DATA_W + GAIN_W;
    localparam int c_frac   = GAIN_W - 2;
    localparam logic [GAIN_W-1:0]       c_unity   = GAIN_W'(1) << c_frac;
    localparam logic signed [ACC_W-1:0] c_half    = ACC_W'(1) << (c_frac - 1);
    localparam logic signed [ACC_W-1:0] c_sat_max = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] c_sat_min = ~c_sat_max;

    state_t                    state_q, state_d;
    logic [DATA_W-1:0]         cap_q    [N_BAND];
    logic [DATA_W-1:0]         cap_d    [N_BAND];
    logic [DATA_W-1:0]         work_q   [N_BAND];
    logic [DATA_W-1:0]         work_d   [N_BAND];
    logic [GAIN_W-1:0]         shadow_q [N_BAND];
    logic [GAIN_W-1:0]         shadow_d [N_BAND];
    logic [GAIN_W-1:0]         active_q [N_BAND];
    logic [GAIN_W-1:0]         active_d [N_BAND];
    logic [N_BAND-1:0]         mask_q, mask_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [2:0]                idx_q, idx_d;
    logic [DATA_W-1:0]         y_out_q, y_out_d;
    logic                      y_valid_q, y_valid_d;
    logic                      overrun_q, overrun_d;

    logic [N_BAND-1:0]         w_mask_all;
    logic                      w_snapshot;
    logic signed [DATA_W-1:0]  w_work_sel;
    logic signed [GAIN_W-1:0]  w_gain_sel;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_rnd;
    logic signed [ACC_W-1:0]   w_shift;
    logic                      w_sat_hi;
    logic                      w_sat_lo;

    assign w_mask_all = mask_q | band_vld;
    assign w_snapshot = (state_q == ST_COLLECT) && (&w_mask_all);

    // Single shared multiplier: operands selected by the MAC index
    always_comb begin
        w_work_sel = '0;
        w_gain_sel = '0;
        for (int k = 0; k < N_BAND; k++) begin
            if (idx_q == 3'(k)) begin
                w_work_sel = work_q[k];
                w_gain_sel = active_q[k];
            end
        end
    end

    assign w_prod     = w_work_sel * w_gain_sel;
    assign w_prod_ext = {{(ACC_W - c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
    assign w_rnd      = acc_q + c_half;
    assign w_shift    = w_rnd >>> c_frac;
    assign w_sat_hi   = w_shift > c_sat_max;
    assign w_sat_lo   = w_shift < c_sat_min;

    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        work_d    = work_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        y_out_d   = y_out_q;
        y_valid_d = 1'b0;
        overrun_d = ovr_clr ? 1'b0 : overrun_q;
        mask_d    = w_snapshot ? '0 : w_mask_all;

        // Capture runs every cycle so next-frame samples never wait on the FSM
        for (int k = 0; k < N_BAND; k++) begin
            if (band_vld[k]) begin
                cap_d[k] = band_data[k*DATA_W +: DATA_W];
            end
            if (gain_we && (gain_addr == 3'(k))) begin
                shadow_d[k] = gain_wdata;
            end
        end
        if (|(band_vld & mask_q)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_COLLECT: begin
                if (w_snapshot) begin
                    work_d   = cap_d;
                    active_d = shadow_d;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + w_prod_ext;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'(N_BAND - 1)) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (w_sat_hi) begin
                    y_out_d = c_sat_max[DATA_W-1:0];
                end else if (w_sat_lo) begin
                    y_out_d = c_sat_min[DATA_W-1:0];
                end else begin
                    y_out_d = w_shift[DATA_W-1:0];
                end
                y_valid_d = 1'b1;
                state_d   = ST_COLLECT;
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_COLLECT;
            mask_q    <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < N_BAND; k++) begin
                cap_q[k]    <= '0;
                work_q[k]   <= '0;
                shadow_q[k] <= c_unity;
                active_q[k] <= c_unity;
            end
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            y_out_q   <= y_out_d;
            y_valid_q <= y_valid_d;
            overrun_q <= overrun_d;
            cap_q     <= cap_d;
            work_q    <= work_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

`ifdef EQ_MIX_CLIP_CNT_EN
    logic [15:0] clip_cnt_q, clip_cnt_d;

    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if ((state_q == ST_OUT) && (w_sat_hi || w_sat_lo) && (clip_cnt_q != 16'hFFFF)) begin
            clip_cnt_d = clip_cnt_q + 16'd1;
        end
        if (ovr_clr) begin
            clip_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_cnt_q <= '0;
        end else begin
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign clip_cnt = clip_cnt_q;
`endif

    assign y_out   = y_out_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q != ST_COLLECT);
    assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_eq_band_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_eq_band_mixer: directed + randomized bench for eq_band_mixer against a  |
// | frame-level behavioural model.                                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_eq_band_mixer;

    localparam int N = 5;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     band_vld = '0;
    logic [N*W-1:0]   band_data = '0;
    logic             gain_we = 1'b0;
    logic [2:0]       gain_addr = '0;
    logic [15:0]      gain_wdata = '0;
    logic             ovr_clr = 1'b0;
    logic [W-1:0]     y_out;
    logic             y_valid;
    logic             busy;
    logic             overrun;
`ifdef EQ_MIX_CLIP_CNT_EN
    logic [15:0]      clip_cnt;
    logic [15:0]      m_clip;
`endif

    eq_band_mixer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .band_vld   (band_vld),
        .band_data  (band_data),
        .gain_we    (gain_we),
        .gain_addr  (gain_addr),
        .gain_wdata (gain_wdata),
        .ovr_clr    (ovr_clr),
        .y_out      (y_out),
        .y_valid    (y_valid),
        .busy       (busy),
        .overrun    (overrun)
`ifdef EQ_MIX_CLIP_CNT_EN
        ,
        .clip_cnt   (clip_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Frame-level model: captured samples, pending mask, gains, and a
    // countdown to the moment a snapshotted frame's result appears.
    logic signed [15:0] m_cap    [N];
    logic signed [15:0] m_shadow [N];
    logic [N-1:0]       m_mask;
    int                 m_left;
    logic [15:0]        m_pend;
    bit                 m_pend_sat;
    logic [15:0]        m_y;
    bit                 m_valid;
    bit                 m_ovr;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mix(output bit sat);
        longint s = 0;
        longint r;
        for (int k = 0; k < N; k++) begin
            s = s + longint'(m_cap[k]) * longint'(m_shadow[k]);
        end
        r   = (s + 64'sd8192) >>> 14;
        sat = 1'b0;
        if (r > 32767) begin
            sat = 1'b1;
            return 16'h7FFF;
        end
        if (r < -32768) begin
            sat = 1'b1;
            return 16'h8000;
        end
        return r[15:0];
    endfunction

    task automatic model_reset();
        m_mask  = '0;
        m_left  = 0;
        m_y     = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_pend  = '0;
        m_pend_sat = 1'b0;
        for (int k = 0; k < N; k++) begin
            m_shadow[k] = 16'sh4000;
            m_cap[k]    = '0;
        end
`ifdef EQ_MIX_CLIP_CNT_EN
        m_clip = '0;
`endif
    endtask

    task automatic model_edge(input logic [N-1:0] vld, input logic [N*W-1:0] data,
                              input logic gwe, input logic [2:0] ga, input logic [15:0] gd,
                              input logic clr);
        bit ovr_new;
        ovr_new = 1'b0;
        m_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (vld[k]) begin
                if (m_mask[k]) ovr_new = 1'b1;
                m_cap[k]  = data[k*W +: W];
                m_mask[k] = 1'b1;
            end
        end
        if (ovr_new) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (gwe && (int'(ga) < N)) m_shadow[ga] = gd;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1'b1;
                m_y     = m_pend;
`ifdef EQ_MIX_CLIP_CNT_EN
                if (m_pend_sat && (m_clip != 16'hFFFF)) m_clip++;
`endif
            end
        end else if (&m_mask) begin
            m_pend = mix(m_pend_sat);
            m_mask = '0;
            m_left = N + 1;
        end
`ifdef EQ_MIX_CLIP_CNT_EN
        if (clr) m_clip = '0;
`endif
    endtask

    task automatic step(input logic [N-1:0] vld, input logic [N*W-1:0] data,
                        input logic gwe, input logic [2:0] ga, input logic [15:0] gd,
                        input logic clr);
        band_vld   = vld;
        band_data  = data;
        gain_we    = gwe;
        gain_addr  = ga;
        gain_wdata = gd;
        ovr_clr    = clr;
        @(posedge clk);
        model_edge(vld, data, gwe, ga, gd, clr);
        #1;
        cyc++;
        check_eq("y_valid", {31'd0, y_valid}, {31'd0, m_valid});
        check_eq("busy",    {31'd0, busy},    {31'd0, (m_left > 0)});
        check_eq("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        check_eq("y_out",   {16'd0, y_out},   {16'd0, m_y});
`ifdef EQ_MIX_CLIP_CNT_EN
        check_eq("clip_cnt", {16'd0, clip_cnt}, {16'd0, m_clip});
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, 3'd0, 16'h0, 1'b0);
    endtask

    task automatic strobe(input logic [N-1:0] vld, input logic [N*W-1:0] data);
        step(vld, data, 1'b0, 3'd0, 16'h0, 1'b0);
    endtask

    task automatic wgain(input logic [2:0] ga, input logic [15:0] gd);
        step('0, '0, 1'b1, ga, gd, 1'b0);
    endtask

    task automatic do_reset();
        band_vld = '0;
        band_data = '0;
        gain_we = 1'b0;
        ovr_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_y_out",   {16'd0, y_out}, 32'h0);
        check_eq("rst_y_valid", {31'd0, y_valid}, 32'h0);
        check_eq("rst_busy",    {31'd0, busy}, 32'h0);
        check_eq("rst_overrun", {31'd0, overrun}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
    endtask

    function automatic logic [N*W-1:0] all_bands(input logic [15:0] v);
        return {N{v}};
    endfunction

    initial begin
        int first_v;
        int second_v;
        int nvalid;
        logic [N*W-1:0] d;
        logic [95:0]    r;
        logic [N-1:0]   rv;

        do_reset();

        // 1: unity gains, all bands 0x1000
        strobe('1, all_bands(16'h1000));
        idle(5);
        check_eq("t1_no_early_valid", {31'd0, y_valid}, 32'h0);
        idle(1);
        check_eq("t1_valid_at_7", {31'd0, y_valid}, 32'h1);
        check_eq("t1_y", {16'd0, y_out}, 32'h5000);
        idle(1);
        check_eq("t1_pulse_1cyc", {31'd0, y_valid}, 32'h0);

        // 2: gain band0=0x2000, others 0; rounding cases
        wgain(3'd0, 16'h2000);
        for (int k = 1; k < N; k++) wgain(3'(k), 16'h0000);
        strobe('1, {{(N-1){16'h7FFF}}, 16'h4000});
        idle(6);
        check_eq("t2_y_half", {16'd0, y_out}, 32'h2000);
        strobe('1, {{(N-1){16'h7FFF}}, 16'h0001});
        idle(6);
        check_eq("t2_round_up", {16'd0, y_out}, 32'h0001);
        strobe('1, {{(N-1){16'h7FFF}}, 16'hFFFF});
        idle(6);
        check_eq("t2_round_neg", {16'd0, y_out}, 32'h0000);

        // 3: saturation both ways
        do_reset();
        strobe('1, all_bands(16'h7000));
        idle(6);
        check_eq("t3_sat_pos", {16'd0, y_out}, 32'h7FFF);
        for (int k = 0; k < N; k++) wgain(3'(k), 16'h7FFF);
        strobe('1, all_bands(16'h8000));
        idle(6);
        check_eq("t3_sat_neg", {16'd0, y_out}, 32'h8000);
`ifdef EQ_MIX_CLIP_CNT_EN
        check_eq("t3_clip_cnt", {16'd0, clip_cnt}, 32'h2);
`endif

        // 4: staggered strobes, band2 twice
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            d  = '0;
            rv = '0;
            case (c)
                0:  begin rv[0] = 1'b1; d[0*W +: W] = 16'h0100; end
                3:  begin rv[1] = 1'b1; d[1*W +: W] = 16'h0200; end
                4:  begin rv[2] = 1'b1; d[2*W +: W] = 16'h7000; end
                6:  begin rv[2] = 1'b1; d[2*W +: W] = 16'h0300; end
                9:  begin rv[3] = 1'b1; d[3*W +: W] = 16'h0400; end
                10: begin rv[4] = 1'b1; d[4*W +: W] = 16'h0500; end
                default: ;
            endcase
            strobe(rv, d);
            if (c == 6) check_eq("t4_overrun_set", {31'd0, overrun}, 32'h1);
        end
        idle(6);
        check_eq("t4_second_value", {16'd0, y_out}, 32'h0F00);
        check_eq("t4_overrun_sticky", {31'd0, overrun}, 32'h1);
        step('0, '0, 1'b0, 3'd0, 16'h0, 1'b1);
        check_eq("t4_overrun_clr", {31'd0, overrun}, 32'h0);

        // 5: gain writes during MAC only affect the next frame
        do_reset();
        strobe('1, all_bands(16'h0100));
        wgain(3'd1, 16'h0000);
        wgain(3'd6, 16'h0000);
        idle(4);
        check_eq("t5_old_gain", {16'd0, y_out}, 32'h0500);
        strobe('1, all_bands(16'h0100));
        idle(6);
        check_eq("t5_new_gain", {16'd0, y_out}, 32'h0400);

        // 6: back-to-back frames, then reset mid-MAC
        do_reset();
        first_v = -1;
        second_v = -1;
        strobe('1, all_bands(16'h0010));
        idle(1);
        strobe('1, all_bands(16'h0020));
        for (int i = 0; i < 16; i++) begin
            idle(1);
            if (y_valid) begin
                if (first_v < 0) first_v = cyc;
                else if (second_v < 0) second_v = cyc;
            end
            if (cyc == first_v)  check_eq("t6_y1", {16'd0, y_out}, 32'h0050);
            if (cyc == second_v) check_eq("t6_y2", {16'd0, y_out}, 32'h00A0);
        end
        check_eq("t6_spacing", second_v - first_v, 32'd7);

        strobe('1, all_bands(16'h0111));
        idle(2);
        do_reset();
        nvalid = 0;
        strobe(5'b01111, all_bands(16'h0001));
        for (int i = 0; i < 12; i++) begin
            idle(1);
            if (y_valid) nvalid++;
        end
        check_eq("t6_no_valid_after_rst", nvalid, 32'd0);
        strobe(5'b10000, all_bands(16'h0001));
        idle(6);
        check_eq("t6_after_rst_y", {16'd0, y_out}, 32'h0005);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r  = {$urandom(), $urandom(), $urandom()};
            d  = r[N*W-1:0];
            rv = '0;
            for (int k = 0; k < N; k++) rv[k] = ($urandom_range(3) == 0);
            if (i == 300) do_reset();
            step(rv, d, ($urandom_range(7) == 0), 3'($urandom_range(7)),
                 16'($urandom_range(16'hFFFF)), ($urandom_range(15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eq_band_mixer.md
Name: eq_band_mixer

Overview:
- Downstream of the five per-band FIR filters (lowpass through highpass) in the 5-band audio equalizer.
- Collects one output sample from each band and applies a programmable per-band gain.
- Sums the weighted bands using one time-shared multiplier, then rounds and saturates to a 16-bit output sample with a valid strobe.
- Feeds the audio output/DAC interface.

Parameters:
- N_BAND, 5, number of bands (1..8).
- DATA_W, 16, band sample and output width, signed.
- GAIN_W, 16, gain width, signed Q2.14; 0x4000 = unity.
- ACC_W, 40, accumulator width, signed.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- band_vld  in  N_BAND  per-band sample strobe, 1-cycle pulse; bit k = band k.
- band_data  in  N_BAND*DATA_W  packed signed samples; band k at bits [k*DATA_W +: DATA_W].
- gain_we  in  1  gain write enable.
- gain_addr  in  3  band index for the gain write.
- gain_wdata  in  GAIN_W  gain value, signed Q2.14.
- ovr_clr  in  1  clears overrun.
- y_out  out  DATA_W  mixed sample, signed.
- y_valid  out  1  1-cycle pulse, y_out updated.
- busy  out  1  high in MAC and OUT states.
- overrun  out  1  sticky duplicate-strobe flag.

Behaviour:
- Reset is asynchronous, active-low, on clk. Reset values:
  - y_out=0, y_valid=0, busy=0, overrun=0.
  - Capture mask=0, accumulator=0, state=COLLECT.
  - All shadow and active gains=0x4000.
- Capture stage, independent of FSM state:
  - On band_vld[k], capture_reg[k] <= band_data slice k and mask[k] <= 1.
  - If mask[k] is already 1 at that edge, the value is overwritten and overrun <= 1.
  - ovr_clr clears overrun. If ovr_clr and a new overrun occur on the same edge, set wins.
- Gain writes:
  - gain_we writes shadow_gain[gain_addr] at the edge.
  - gain_addr >= N_BAND is ignored.
  - Shadow gains are copied to active gains only at the snapshot edge, so a frame always uses a consistent gain set.
- FSM states: COLLECT, MAC, OUT.
- COLLECT:
  - When mask (including strobes arriving this edge) is all ones, take the snapshot at that edge:
    - work_reg <= capture values, including same-edge strobes.
    - active_gain <= shadow_gain, including a same-edge gain write.
    - mask <= 0.
    - acc <= 0, idx <= 0, go to MAC.
- MAC:
  - Each cycle, acc <= acc + work_reg[idx]*active_gain[idx] (32-bit signed product, sign-extended to ACC_W); idx++.
  - After N_BAND accumulations, go to OUT.
  - Strobes arriving during MAC/OUT go to the capture stage for the next frame. They never disturb work_reg.
- OUT:
  - y_out <= sat((acc + 2^13) >>> 14). Rounding is round-half-up; the arithmetic shift is performed at ACC_W.
  - Saturation limits: >0x7FFF becomes 0x7FFF; <-0x8000 becomes 0x8000.
  - y_valid <= 1 for exactly one cycle, then return to COLLECT.
  - If the mask is already full on entry to COLLECT, the next snapshot happens on the first COLLECT edge, with no idle cycle.
- Latency:
  - Snapshot edge E0. MAC occupies E1..E(N_BAND). OUT is edge E(N_BAND+1).
  - y_valid is high the cycle after E(N_BAND+1): 7 edges after the last strobe for N_BAND=5.
  - Minimum frame period is N_BAND+2 cycles.
  - busy is asserted for MAC and OUT.
- Reset mid-operation aborts the frame. No y_valid is produced, and captured samples are discarded.
- No overflow is possible in acc: 8 bands × 2^31 fits in 40 bits.

Optional Feature:
- Macro EQ_MIX_CLIP_CNT_EN.
- When defined:
  - Adds output clip_cnt, 16 bits, reset 0.
  - Increments by one at each OUT edge where saturation occurred (positive or negative).
  - Saturates at 0xFFFF.
  - Cleared by ovr_clr; clear wins over a simultaneous increment.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
1. Reset, then all bands=0x1000 strobed together, unity gains -> y_out=0x5000, y_valid 7 edges after strobe, one-cycle pulse.
2. Write gain band0=0x2000, others=0x0000; band0=0x4000, others 0x7FFF -> y_out=0x2000. Band0=0x0001 -> y_out=0x0001 (round half up). Band0=0xFFFF -> y_out=0x0000.
3. All bands=0x7000 at unity -> y_out=0x7FFF. All bands=0x8000 at gain 0x7FFF -> y_out=0x8000. With EQ_MIX_CLIP_CNT_EN, clip_cnt=2.
4. Bands strobed on staggered cycles 0,3,4,9,10, band2 strobed twice before the frame completes -> second band2 value used, overrun=1 until ovr_clr pulse.
5. gain_we with gain_addr=1 (wdata 0x0000) during MAC; band1 nonzero -> current frame still uses the old gain, next frame excludes band1. gain_addr=6 write -> no change.
6. Next-frame strobes during MAC complete the mask -> back-to-back frames, y_valid 7 cycles apart. Assert rst_n low during MAC -> no y_valid, outputs 0, and the next frame requires all five new strobes.
